// File: rtl/pwm_pkg.sv
// ============================================================================
// Module  : pwm_pkg
// Purpose : Shared encodings and defaults for the PWM generator/decoder pair.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

    localparam int DUTY_W          = 8;
    localparam int CNT_W_DEF       = 16;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int TIMEOUT_DEF     = 1024;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } meas_state_e;

endpackage

`default_nettype wire

// File: rtl/serial_divider.sv
// ============================================================================
// Module  : serial_divider
// Purpose : Restoring divider producing one quotient bit per clock.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_divider #(
    parameter int DVD_W = 24,
    parameter int DVS_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [DVD_W-1:0] dividend_i,
    input  logic [DVS_W-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [DVD_W-1:0] quotient_o
);

    localparam int CNT_W = $clog2(DVD_W + 1);

    logic [DVD_W-1:0] quo_q;
    logic [DVS_W-1:0] rem_q;
    logic [DVS_W-1:0] dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;

    logic [DVS_W:0]   w_shift;
    logic [DVS_W:0]   w_diff;
    logic             w_qbit;

    // quo_q shifts the dividend out at the top while quotient bits enter below
    assign w_shift = {rem_q, quo_q[DVD_W-1]};
    assign w_diff  = w_shift - {1'b0, dvs_q};
    assign w_qbit  = ~w_diff[DVS_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i && !busy_q) begin
                quo_q  <= dividend_i;
                rem_q  <= '0;
                dvs_q  <= divisor_i;
                cnt_q  <= CNT_W'(DVD_W);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                quo_q <= {quo_q[DVD_W-2:0], w_qbit};
                rem_q <= w_qbit ? w_diff[DVS_W-1:0] : w_shift[DVS_W-1:0];
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign quotient_o = quo_q;

endmodule

`default_nettype wire

// File: rtl/pwm_decoder.sv
// ============================================================================
// Module  : pwm_decoder
// Purpose : Measures an external PWM input, recovering duty and period.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pwm_decoder
    import pwm_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty_out,
    output logic [CNT_W-1:0]  period_out,
    output logic              duty_valid,
    output logic              no_signal,
    output logic              drop
);

    localparam int QUO_W  = CNT_W + DUTY_W;
    localparam int WARM   = SYNC_STAGES + 1;
    localparam int WARM_W = $clog2(WARM + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [WARM_W-1:0]      warm_q;

    meas_state_e            state_q, state_d;
    logic [CNT_W-1:0]       p_cnt_q, p_cnt_d;
    logic [CNT_W-1:0]       h_lat_q, h_lat_d;
    logic [CNT_W-1:0]       per_lat_q, per_lat_d;
    logic [CNT_W-1:0]       idle_q, idle_d;
    logic                   stuck_q, stuck_d;
    logic                   pend_q, pend_d;
    logic                   pend_lvl_q, pend_lvl_d;
    logic [DUTY_W-1:0]      duty_q, duty_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic                   valid_q, valid_d;
    logic                   nosig_q, nosig_d;
    logic                   drop_q, drop_d;

    logic                   w_warm, w_level, w_rise, w_fall, w_edge;
    logic                   w_complete, w_to_hit, w_to_fire, w_start;
    logic                   w_div_busy, w_div_done;
    logic [CNT_W-1:0]       w_p_inc;
    logic [QUO_W-1:0]       w_quot;
    logic [DUTY_W-1:0]      w_duty_sat;

    // Edges are masked until the chain holds real pin samples, so a pin that
    // is already high at reset release is not mistaken for a rising edge.
    assign w_warm  = (warm_q == WARM_W'(WARM));
    assign w_level = sync_q[SYNC_STAGES-1];
    assign w_rise  = w_warm &  w_level & ~prev_q;
    assign w_fall  = w_warm & ~w_level &  prev_q;
    assign w_edge  = w_rise | w_fall;

    assign w_to_hit  = w_warm && !w_edge && !stuck_q && (idle_q == CNT_W'(TIMEOUT - 1));
    assign w_to_fire = (w_to_hit && !w_div_done) || pend_q;
    assign w_p_inc   = (p_cnt_q == '1) ? p_cnt_q : p_cnt_q + CNT_W'(1);
    assign w_start   = w_complete && !w_div_busy;

    always_comb begin
        state_d    = state_q;
        p_cnt_d    = p_cnt_q;
        h_lat_d    = h_lat_q;
        w_complete = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (w_rise) begin
                    state_d = ST_HIGH;
                    p_cnt_d = CNT_W'(1);
                end
            end
            ST_HIGH: begin
                p_cnt_d = w_p_inc;
                if (w_fall) begin
                    state_d = ST_LOW;
                    h_lat_d = p_cnt_q;
                end
            end
            ST_LOW: begin
                p_cnt_d = w_p_inc;
                if (w_rise) begin
                    w_complete = 1'b1;
                    state_d    = ST_HIGH;
                    p_cnt_d    = CNT_W'(1);
                end
            end
            default: state_d = ST_WAIT;
        endcase
        if (w_to_hit) begin
            state_d = ST_WAIT;
        end
    end

    serial_divider #(
        .DVD_W (QUO_W),
        .DVS_W (CNT_W)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (w_start),
        .dividend_i ({h_lat_q, {DUTY_W{1'b0}}}),
        .divisor_i  (p_cnt_q),
        .busy_o     (w_div_busy),
        .done_o     (w_div_done),
        .quotient_o (w_quot)
    );

    assign w_duty_sat = (|w_quot[QUO_W-1:DUTY_W]) ? '1 : w_quot[DUTY_W-1:0];

    // A timeout coinciding with a divider result is deferred by one cycle
    always_comb begin
        idle_d     = idle_q;
        stuck_d    = stuck_q;
        pend_d     = w_to_hit && w_div_done;
        pend_lvl_d = w_to_hit ? w_level : pend_lvl_q;
        per_lat_d  = w_start ? p_cnt_q : per_lat_q;
        drop_d     = w_complete && w_div_busy;
        duty_d     = duty_q;
        period_d   = period_q;
        valid_d    = 1'b0;
        nosig_d    = nosig_q;
        if (w_edge || !w_warm) begin
            idle_d = '0;
        end else if (!stuck_q) begin
            idle_d = idle_q + CNT_W'(1);
        end
        if (w_edge) begin
            stuck_d = 1'b0;
        end else if (w_to_hit) begin
            stuck_d = 1'b1;
        end
        if (w_div_done) begin
            duty_d   = w_duty_sat;
            period_d = per_lat_q;
            valid_d  = 1'b1;
            nosig_d  = 1'b0;
        end else if (w_to_fire) begin
            duty_d   = (pend_q ? pend_lvl_q : w_level) ? '1 : '0;
            period_d = '0;
            valid_d  = 1'b1;
            nosig_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            prev_q     <= 1'b0;
            warm_q     <= '0;
            state_q    <= ST_WAIT;
            p_cnt_q    <= '0;
            h_lat_q    <= '0;
            per_lat_q  <= '0;
            idle_q     <= '0;
            stuck_q    <= 1'b0;
            pend_q     <= 1'b0;
            pend_lvl_q <= 1'b0;
            duty_q     <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            nosig_q    <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            prev_q     <= sync_q[SYNC_STAGES-1];
            if (!w_warm) begin
                warm_q <= warm_q + WARM_W'(1);
            end
            state_q    <= state_d;
            p_cnt_q    <= p_cnt_d;
            h_lat_q    <= h_lat_d;
            per_lat_q  <= per_lat_d;
            idle_q     <= idle_d;
            stuck_q    <= stuck_d;
            pend_q     <= pend_d;
            pend_lvl_q <= pend_lvl_d;
            duty_q     <= duty_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            nosig_q    <= nosig_d;
            drop_q     <= drop_d;
        end
    end

    assign duty_out   = duty_q;
    assign period_out = period_q;
    assign duty_valid = valid_q;
    assign no_signal  = nosig_q;
    assign drop       = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_decoder.sv
// ============================================================================
// Module  : tb_pwm_decoder
// Purpose : Directed self-checking bench for pwm_decoder.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pwm_decoder;

    localparam int CNT_W       = 16;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT     = 1024;
    localparam int LAT         = SYNC_STAGES + 1 + CNT_W + 9;

    logic             clk;
    logic             rst_n;
    logic             pwm_in;
    logic [7:0]       duty_out;
    logic [CNT_W-1:0] period_out;
    logic             duty_valid;
    logic             no_signal;
    logic             drop;

    int n_vec    = 0;
    int n_bad    = 0;
    int n_drop   = 0;
    int cyc      = 0;
    int wrap_cyc = 0;
    int g_high   = 0;
    int g_period = 256;
    int g_req    = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    pwm_decoder #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwm_in     (pwm_in),
        .duty_out   (duty_out),
        .period_out (period_out),
        .duty_valid (duty_valid),
        .no_signal  (no_signal),
        .drop       (drop)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // PWM generator: high for the first g_high of every g_period cycles.
    // New settings take effect at the next period start, or at once on g_req.
    initial begin
        int cnt, hi, per, ack;
        cnt = 0; hi = 0; per = 256; ack = 0;
        pwm_in = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (g_req != ack) begin
                ack = g_req; cnt = 0; hi = g_high; per = g_period; wrap_cyc = cyc;
            end else begin
                cnt++;
                if (cnt >= per) begin
                    cnt = 0; hi = g_high; per = g_period; wrap_cyc = cyc;
                end
            end
            pwm_in = (cnt < hi);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (drop) n_drop++;
        end
    end

    task automatic wait_valid();
        int n;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!duty_valid && n < 4000);
        if (!duty_valid) chk("valid_wait", 0, 1);
    endtask

    task automatic skip(input int n);
        repeat (n) wait_valid();
    endtask

    task automatic set_gen(input int h, input int p);
        g_high = h; g_period = p;
    endtask

    initial begin
        int k, d, d0;
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_duty", duty_out, 0);
        chk("rst_period", period_out, 0);
        chk("rst_valid", duty_valid, 0);
        chk("rst_nosig", no_signal, 0);
        chk("rst_drop", drop, 0);

        // constant low from reset
        @(negedge clk) rst_n = 1'b1;
        k = 0;
        do begin
            @(posedge clk); #1; k++;
        end while (!duty_valid && k < 3000);
        chk("lo_to_lat", k, TIMEOUT + SYNC_STAGES + 1);
        chk("lo_to_duty", duty_out, 0);
        chk("lo_to_period", period_out, 0);
        chk("lo_to_nosig", no_signal, 1);
        k = 0;
        repeat (1500) begin
            @(posedge clk); #1;
            if (duty_valid) k++;
        end
        chk("lo_to_once", k, 0);

        // constant high from reset, then resume at D=100
        @(negedge clk) rst_n = 1'b0;
        g_high = 256; g_period = 256; g_req++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_valid();
        chk("hi_to_duty", duty_out, 255);
        chk("hi_to_period", period_out, 0);
        chk("hi_to_nosig", no_signal, 1);
        set_gen(100, 256);
        wait_valid();
        chk("d100_duty", duty_out, 100);
        chk("d100_period", period_out, 256);
        chk("d100_nosig", no_signal, 0);

        set_gen(128, 256);
        skip(2);
        d0 = n_drop;
        repeat (3) begin
            wait_valid();
            chk("d128_duty", duty_out, 128);
            chk("d128_period", period_out, 256);
            chk("d128_nosig", no_signal, 0);
        end
        chk("d128_drops", n_drop - d0, 0);

        set_gen(1, 256);
        skip(2);
        wait_valid();
        chk("d1_duty", duty_out, 1);
        chk("d1_period", period_out, 256);

        set_gen(255, 256);
        skip(2);
        wait_valid();
        chk("d255_duty", duty_out, 255);
        chk("d255_period", period_out, 256);

        set_gen(64, 256);
        skip(2);
        wait_valid();
        chk("d64_duty", duty_out, 64);
        set_gen(200, 256);
        d = 0;
        for (int i = 0; i < 3; i++) begin
            wait_valid();
            d = int'(duty_out);
            chk("sw_legal", int'(d == 64 || d == 200), 1);
        end
        chk("sw_final", d, 200);

        // period 10, high 3: divider outlasts the period, so some are dropped
        set_gen(3, 10);
        d0 = n_drop;
        skip(3);
        repeat (3) begin
            wait_valid();
            chk("p10_duty", duty_out, 76);
            chk("p10_period", period_out, 10);
        end
        chk("p10_drops", int'(n_drop > d0), 1);

        // reset in the middle of a division
        set_gen(128, 256);
        skip(3);
        wait_valid();
        repeat (236) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_duty", duty_out, 0);
        chk("mid_rst_period", period_out, 0);
        chk("mid_rst_valid", duty_valid, 0);
        repeat (40) @(posedge clk);
        #1;
        chk("mid_rst_hold", duty_valid, 0);
        @(negedge clk) rst_n = 1'b1;
        k = 0;
        do begin
            @(posedge clk); #1; k++;
        end while (!duty_valid && k < 4000);
        chk("post_rst_min", int'(k >= 256), 1);
        chk("post_rst_lat", cyc - wrap_cyc, LAT);
        chk("post_rst_duty", duty_out, 128);
        chk("post_rst_period", period_out, 256);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
